// File: rtl/indexor_lut_arbiter_pkg.sv
// Shared types for the indexor LUT arbiter.
// FSM states and the table reset pattern.
package indexor_lut_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_e;

    function automatic int unsigned table_reset(int unsigned k);
        return k + 1;
    endfunction

endpackage

// File: rtl/indexor_lut_arbiter_if.sv
// Request/response bundle between clients and the LUT arbiter.
// master = client side, slave = arbiter side.
interface indexor_lut_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int IDX_W  = 2,
    parameter int DATA_W = 4,
    parameter int ID_W   = $clog2(NREQ)
) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*IDX_W-1:0] req_index;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_ready;

    modport master (
        output req_valid, req_index, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_index, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/indexor_lut_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester
// at or after the pointer, wrapping modulo NREQ.
module indexor_lut_arbiter_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] pointer,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

    logic            found;
    logic [ID_W-1:0] k;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        k        = '0;
        for (int off = 0; off < NREQ; off++) begin
            k = ID_W'((int'(pointer) + off) % NREQ);
            if (!found && valid[k]) begin
                grant[k] = 1'b1;
                grant_id = k;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/indexor_lut_arbiter.sv
// Shared lookup table with round-robin access for NREQ clients
// and a run-time config write port.
module indexor_lut_arbiter
    import indexor_lut_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 2,
    parameter int DATA_W = 4,
    parameter int ID_W   = $clog2(NREQ)
) (
    input  logic [1:0]           clock_reset,
    indexor_lut_arbiter_if.slave bus,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_addr,
    input  logic [DATA_W-1:0]    cfg_data,
    output logic                 busy
);

    logic clk;
    logic rst_n;

    assign clk   = clock_reset[0];
    assign rst_n = clock_reset[1];

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] table_q [DEPTH];
    logic [DATA_W-1:0] table_d [DEPTH];

    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_id;

    indexor_lut_arbiter_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .valid    (bus.req_valid),
        .pointer  (ptr_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // Gated by rst_n so no grant is offered while reset is held.
    assign bus.req_ready = (state_q == IDLE && rst_n) ? grant : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        table_d     = table_q;
        if (cfg_we) begin
            table_d[cfg_addr] = cfg_data;
        end
        unique case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    idx_d   = bus.req_index[int'(grant_id)*IDX_W +: IDX_W];
                    id_d    = grant_id;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                // Reads the pre-write table, so a same-cycle cfg write is not seen.
                rsp_data_d  = table_q[idx_q];
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = (id_q == ID_W'(NREQ-1)) ? '0 : id_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= IDX_W'(DEPTH-1);
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                table_q[k] <= DATA_W'(table_reset(k));
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            table_q     <= table_d;
        end
    end

endmodule

// File: tb/tb_indexor_lut_arbiter.sv
// Scoreboard bench for indexor_lut_arbiter: directed scenarios
// followed by randomized traffic against a behavioural table model.
module tb_indexor_lut_arbiter;

    localparam int NREQ   = 4;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = 2;
    localparam int DATA_W = 4;
    localparam int ID_W   = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        clock_reset;
    logic              cfg_we = 1'b0;
    logic [IDX_W-1:0]  cfg_addr = '0;
    logic [DATA_W-1:0] cfg_data = '0;
    logic              busy;

    assign clock_reset = {rst_n, clk};

    indexor_lut_arbiter_if #(
        .NREQ(NREQ), .IDX_W(IDX_W), .DATA_W(DATA_W)
    ) bus ();

    indexor_lut_arbiter #(
        .NREQ(NREQ), .DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)
    ) dut (
        .clock_reset (clock_reset),
        .bus         (bus),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    rsp_t              exp_q[$];
    int                acc_cyc_q[$];
    int                acc_id_q[$];
    logic [DATA_W-1:0] mtab [DEPTH];
    int                mptr = 0;
    int                pend_id = 0;
    int                pend_idx = 0;
    int                last_acc = -100;
    bit                pend = 0;
    bit                outstanding = 0;
    bit                prev_valid = 0;
    bit                prev_ready = 0;
    rsp_t              prev_rsp = '0;
    logic [NREQ-1:0]   acc_mask = '0;
    logic [DATA_W-1:0] last_rsp_data = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_winner(logic [NREQ-1:0] v, int p);
        for (int o = 0; o < NREQ; o++) begin
            if (v[(p + o) % NREQ]) return (p + o) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) mtab[k] = DATA_W'(k + 1);
        mptr = 0;
        pend = 0;
        outstanding = 0;
        exp_q.delete();
        prev_valid = 0;
        prev_ready = 0;
        acc_mask = '0;
        last_acc = -100;
    endtask

    // Monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int w;
        rsp_t got, want;
        cyc++;
        if (!rst_n) begin
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_busy", busy, 0);
            model_reset();
        end else begin
            w = rr_winner(bus.req_valid, mptr);
            exp_rdy = '0;
            if (!outstanding && w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("busy", busy, outstanding);
            got.data = bus.rsp_data;
            got.id = bus.rsp_id;
            if (prev_valid && !prev_ready) begin
                chk("hold_valid", bus.rsp_valid, 1);
                chk("hold_rsp", got, prev_rsp);
            end
            if (bus.rsp_valid && !prev_valid) chk("rsp_latency", cyc - last_acc, 2);
            if (pend) begin
                want.data = mtab[pend_idx];
                want.id = ID_W'(pend_id);
                exp_q.push_back(want);
                pend = 0;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected: got data %0d id %0d, required no response",
                             got.data, got.id);
                end else begin
                    checks--;
                    want = exp_q.pop_front();
                    chk("rsp_data", got.data, want.data);
                    chk("rsp_id", got.id, want.id);
                end
                last_rsp_data = got.data;
                outstanding = 0;
                mptr = (pend_id + 1) % NREQ;
            end
            if (cfg_we) mtab[cfg_addr] = cfg_data;
            acc_mask = bus.req_valid & bus.req_ready;
            if (|acc_mask) begin
                pend_id = w;
                pend_idx = int'(bus.req_index[w*IDX_W +: IDX_W]);
                pend = 1;
                outstanding = 1;
                last_acc = cyc;
                acc_cyc_q.push_back(cyc);
                acc_id_q.push_back(w);
            end
            prev_valid = bus.rsp_valid;
            prev_ready = bus.rsp_ready;
            prev_rsp = got;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~acc_mask;
    endtask

    task automatic post(int k, int idx);
        bus.req_valid[k] = 1'b1;
        bus.req_index[k*IDX_W +: IDX_W] = IDX_W'(idx);
    endtask

    task automatic drain(int maxc);
        int n = 0;
        while ((bus.req_valid != 0 || busy) && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        if (bus.req_valid != 0 || busy) begin
            failures++;
            $display("FAIL drain_timeout: got req_valid %b busy %0d, required idle", bus.req_valid, busy);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 0);
        chk({tag, "_rsp_id"}, bus.rsp_id, 0);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bus.req_valid = '0;
        bus.req_index = '0;
        bus.rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Single lookup of index 3 from requester 0
        post(0, 3);
        drain(20);
        chk("t1_data", last_rsp_data, 4);

        // Park the pointer at 0, then all four at once
        post(3, 0);
        drain(20);
        n0 = acc_cyc_q.size();
        for (int k = 0; k < NREQ; k++) post(k, k);
        drain(40);
        chk("t2_grants", acc_cyc_q.size() - n0, 4);
        if (acc_cyc_q.size() - n0 == 4) begin
            for (int i = 0; i < 4; i++) chk("t2_order", acc_id_q[n0 + i], i);
            for (int i = 1; i < 4; i++)
                chk("t2_spacing", acc_cyc_q[n0 + i] - acc_cyc_q[n0 + i - 1], 3);
        end

        // Back-pressure in RESP
        bus.rsp_ready = 1'b0;
        post(2, 1);
        tick();
        post(0, 2);
        repeat (8) tick();
        chk("t3_stalled_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        drain(30);
        chk("t3_next_id", acc_id_q[acc_id_q.size() - 1], 0);

        // Config write in IDLE, then a write colliding with a lookup
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 4'd7;
        tick();
        cfg_we = 1'b0;
        post(1, 2);
        tick();
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 4'd9;
        tick();
        cfg_we = 1'b0;
        drain(20);
        chk("t4_old_value", last_rsp_data, 3);
        post(2, 2);
        drain(20);
        chk("t4_new_value", last_rsp_data, 9);

        // Asynchronous reset during LOOKUP
        post(0, 1);
        tick();
        post(2, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (2) tick();
        bus.req_valid = '0;
        @(posedge clk);
        #4 rst_n = 1'b1;
        tick();
        post(0, 1);
        drain(20);
        chk("t5_table_restored", last_rsp_data, 2);
        post(1, 2);
        drain(20);
        chk("t5_entry2_restored", last_rsp_data, 3);

        // Pointer wrap after id 3
        post(3, 0);
        drain(20);
        n0 = acc_id_q.size();
        post(3, 1);
        post(1, 3);
        drain(30);
        chk("t6_grants", acc_id_q.size() - n0, 2);
        if (acc_id_q.size() - n0 == 2) begin
            chk("t6_first", acc_id_q[n0], 1);
            chk("t6_second", acc_id_q[n0 + 1], 3);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!bus.req_valid[k] && $urandom_range(0, 2) == 0)
                    post(k, int'($urandom_range(0, DEPTH - 1)));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            cfg_we = ($urandom_range(0, 4) == 0);
            cfg_addr = IDX_W'($urandom_range(0, DEPTH - 1));
            cfg_data = DATA_W'($urandom);
            tick();
        end
        cfg_we = 1'b0;
        bus.rsp_ready = 1'b1;
        drain(100);
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("no_outstanding", outstanding, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
